// File: rtl/universal_register_pkg.sv
// Shared mode encodings for the universal register and anything that drives it.
package universal_register_pkg;

    localparam int MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_HOLD = 3'd0;
    localparam mode_t MODE_LOAD = 3'd1;
    localparam mode_t MODE_SHL  = 3'd2;
    localparam mode_t MODE_SHR  = 3'd3;
    localparam mode_t MODE_ROL  = 3'd4;
    localparam mode_t MODE_ROR  = 3'd5;
    localparam mode_t MODE_INC  = 3'd6;
    localparam mode_t MODE_DEC  = 3'd7;

endpackage

// File: rtl/universal_register_next.sv
// Combinational next-state for the universal register: decodes the mode into
// the next contents, next carry and whether this edge updates at all.
module universal_register_next
    import universal_register_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [MODE_W-1:0] i_mode,
    input  logic [N-1:0]      i_q,
    input  logic [N-1:0]      i_d,
    input  logic              i_ser_l,
    input  logic              i_ser_r,
    output logic [N-1:0]      o_q,
    output logic              o_carry,
    output logic              o_upd
);

    logic [N:0] w_inc;

    // Increment is done at N+1 bits so the top bit is the carry out.
    assign w_inc = {1'b0, i_q} + {{N{1'b0}}, 1'b1};

    always_comb begin
        o_q     = i_q;
        o_carry = 1'b0;
        o_upd   = 1'b1;
        case (i_mode)
            MODE_HOLD: o_upd = 1'b0;
            MODE_LOAD: o_q = i_d;
            MODE_SHL: begin
                o_q     = {i_q[N-2:0], i_ser_r};
                o_carry = i_q[N-1];
            end
            MODE_SHR: begin
                o_q     = {i_ser_l, i_q[N-1:1]};
                o_carry = i_q[0];
            end
            MODE_ROL: begin
                o_q     = {i_q[N-2:0], i_q[N-1]};
                o_carry = i_q[N-1];
            end
            MODE_ROR: begin
                o_q     = {i_q[0], i_q[N-1:1]};
                o_carry = i_q[0];
            end
            MODE_INC: begin
                o_q     = w_inc[N-1:0];
                o_carry = w_inc[N];
            end
            MODE_DEC: begin
                o_q     = i_q - {{(N-1){1'b0}}, 1'b1};
                o_carry = (i_q == '0);
            end
            default: o_upd = 1'b0;
        endcase
    end

endmodule

// File: rtl/universal_register.sv
// N-bit universal register: load, shift/rotate, inc/dec with registered carry
// and a combinational zero flag. Clear is asynchronous, active low.
module universal_register
    import universal_register_pkg::*;
#(
    parameter int N = 8
) (
    input  logic              Clk,
    input  logic              Clear,
    input  logic              Enable,
    input  logic [MODE_W-1:0] Mode,
    input  logic [N-1:0]      IN,
    input  logic              SerL,
    input  logic              SerR,
    output logic [N-1:0]      OUT,
    output logic              Carry,
    output logic              Zero
);

    logic [N-1:0] r_out;
    logic         r_carry;
    logic [N-1:0] w_next_q;
    logic         w_next_carry;
    logic         w_upd;

    universal_register_next #(.N(N)) u_next (
        .i_mode  (Mode),
        .i_q     (r_out),
        .i_d     (IN),
        .i_ser_l (SerL),
        .i_ser_r (SerR),
        .o_q     (w_next_q),
        .o_carry (w_next_carry),
        .o_upd   (w_upd)
    );

    // HOLD and Enable=0 both leave carry untouched, so gate the whole update.
    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            r_out   <= '0;
            r_carry <= 1'b0;
        end else if (Enable && w_upd) begin
            r_out   <= w_next_q;
            r_carry <= w_next_carry;
        end
    end

    assign OUT   = r_out;
    assign Carry = r_carry;
    assign Zero  = (r_out == '0);

endmodule

// File: tb/tb_universal_register.sv
// Directed scoreboard bench for universal_register at N=8 and N=16.
module tb_universal_register;
    import universal_register_pkg::*;

    typedef struct {
        string       tag;
        bit          wide;
        logic [15:0] out;
        logic        carry;
    } exp_t;

    logic              Clk = 1'b0;
    logic              Clear;
    logic              Enable;
    logic [MODE_W-1:0] Mode;
    logic [15:0]       r_in;
    logic              SerL, SerR;
    logic [7:0]        a_out;
    logic              a_carry, a_zero;
    logic [15:0]       b_out;
    logic              b_carry, b_zero;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 Clk = ~Clk;

    universal_register #(.N(8)) dut_a (
        .Clk(Clk), .Clear(Clear), .Enable(Enable), .Mode(Mode), .IN(r_in[7:0]),
        .SerL(SerL), .SerR(SerR), .OUT(a_out), .Carry(a_carry), .Zero(a_zero)
    );

    universal_register #(.N(16)) dut_b (
        .Clk(Clk), .Clear(Clear), .Enable(Enable), .Mode(Mode), .IN(r_in),
        .SerL(SerL), .SerR(SerR), .OUT(b_out), .Carry(b_carry), .Zero(b_zero)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_push(input string tag, input bit wide,
                               input logic [15:0] eo, input logic ec);
        exp_t e;
        e.tag = tag; e.wide = wide; e.out = eo; e.carry = ec;
        sb.push_back(e);
    endtask

    task automatic expect_pop();
        exp_t e;
        if (sb.size() == 0) begin
            total++; bad++;
            $error("FAIL scoreboard_empty: got 0 entries want 1");
            return;
        end
        e = sb.pop_front();
        if (e.wide) begin
            chk({e.tag, ".out"},   b_out,          e.out);
            chk({e.tag, ".carry"}, {15'd0, b_carry}, {15'd0, e.carry});
            chk({e.tag, ".zero"},  {15'd0, b_zero},  {15'd0, (e.out == 16'd0)});
        end else begin
            chk({e.tag, ".out"},   {8'd0, a_out},    e.out);
            chk({e.tag, ".carry"}, {15'd0, a_carry}, {15'd0, e.carry});
            chk({e.tag, ".zero"},  {15'd0, a_zero},  {15'd0, (e.out == 16'd0)});
        end
    endtask

    // Drive inputs, record the expected post-edge state, clock once, compare.
    task automatic step(input string tag, input logic [2:0] m, input logic [15:0] d,
                        input logic en, input logic sl, input logic sr, input bit wide,
                        input logic [15:0] eo, input logic ec);
        Mode = m; r_in = d; Enable = en; SerL = sl; SerR = sr;
        expect_push(tag, wide, eo, ec);
        @(posedge Clk); #1;
        expect_pop();
    endtask

    initial begin
        Clear = 1'b0; Enable = 1'b1; Mode = MODE_LOAD; r_in = 16'h00F6;
        SerL = 1'b0; SerR = 1'b0;
        #2;
        expect_push("reset", 0, 16'h00, 1'b0); expect_pop();
        @(posedge Clk); #1;
        expect_push("reset_edge_ignored", 0, 16'h00, 1'b0); expect_pop();
        Clear = 1'b1;
        step("load_f6", MODE_LOAD, 16'h00F6, 1, 0, 0, 0, 16'hF6, 0);

        step("load_55", MODE_LOAD, 16'h0055, 1, 0, 0, 0, 16'h55, 0);
        step("shl_1",   MODE_SHL,  16'h0000, 1, 0, 1, 0, 16'hAB, 0);
        step("shl_0",   MODE_SHL,  16'h0000, 1, 0, 0, 0, 16'h56, 1);

        step("load_81", MODE_LOAD, 16'h0081, 1, 0, 0, 0, 16'h81, 0);
        step("shr_0",   MODE_SHR,  16'h0000, 1, 0, 0, 0, 16'h40, 1);
        step("shr_1",   MODE_SHR,  16'h0000, 1, 1, 0, 0, 16'hA0, 0);
        step("load_01", MODE_LOAD, 16'h0001, 1, 0, 0, 0, 16'h01, 0);
        step("ror",     MODE_ROR,  16'h0000, 1, 0, 0, 0, 16'h80, 1);
        step("rol",     MODE_ROL,  16'h0000, 1, 0, 0, 0, 16'h01, 1);
        step("ror_02",  MODE_LOAD, 16'h0002, 1, 0, 0, 0, 16'h02, 0);
        step("ror_nc",  MODE_ROR,  16'h0000, 1, 1, 1, 0, 16'h01, 0);

        step("load_ff", MODE_LOAD, 16'h00FF, 1, 0, 0, 0, 16'hFF, 0);
        step("inc_wrap", MODE_INC, 16'h0000, 1, 0, 0, 0, 16'h00, 1);
        step("dec_wrap", MODE_DEC, 16'h0000, 1, 0, 0, 0, 16'hFF, 1);
        step("dec",      MODE_DEC, 16'h0000, 1, 0, 0, 0, 16'hFE, 0);
        step("inc",      MODE_INC, 16'h0000, 1, 0, 0, 0, 16'hFF, 0);

        step("load_9e", MODE_LOAD, 16'h009E, 1, 0, 0, 0, 16'h9E, 0);
        step("shl_3c",  MODE_SHL,  16'h0000, 1, 0, 0, 0, 16'h3C, 1);
        for (int i = 0; i < 3; i++)
            step("en0_load", MODE_LOAD, 16'h0012, 0, 0, 0, 0, 16'h3C, 1);
        step("en0_inc", MODE_INC,  16'h0000, 0, 0, 0, 0, 16'h3C, 1);
        step("hold",    MODE_HOLD, 16'h0012, 1, 1, 1, 0, 16'h3C, 1);

        step("load_10", MODE_LOAD, 16'h0010, 1, 0, 0, 0, 16'h10, 0);
        step("inc_11",  MODE_INC,  16'h0000, 1, 0, 0, 0, 16'h11, 0);
        @(negedge Clk);
        Clear = 1'b0; #1;
        expect_push("clear_mid", 0, 16'h00, 1'b0); expect_pop();
        @(posedge Clk); #1;
        expect_push("clear_held", 0, 16'h00, 1'b0); expect_pop();
        // Released just after the edge, so that edge saw Clear low.
        Clear = 1'b1;
        step("inc_after_clear", MODE_INC, 16'h0000, 1, 0, 0, 0, 16'h01, 0);

        step("w_load_ffff", MODE_LOAD, 16'hFFFF, 1, 0, 0, 1, 16'hFFFF, 0);
        step("w_inc_wrap",  MODE_INC,  16'h0000, 1, 0, 0, 1, 16'h0000, 1);
        step("w_dec_wrap",  MODE_DEC,  16'h0000, 1, 0, 0, 1, 16'hFFFF, 1);
        step("w_shl",       MODE_SHL,  16'h0000, 1, 0, 0, 1, 16'hFFFE, 1);
        step("w_shr",       MODE_SHR,  16'h0000, 1, 0, 0, 1, 16'h7FFF, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
